// File: rtl/uart_tx.sv
// UART serializer: start, LSB-first data, optional parity, stop bits, each one cke interval long.
// Line falls one cycle after the first cke following accept; ready stays low for the whole frame, so upstream holds its word.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [IW-1:0]        idx, idx_nxt, idx_inc;
    logic                 cnt, cnt_nxt;
    logic                 par_bit, par_nxt;
    logic                 tx_nxt, done_nxt, ready_nxt;

    assign idx_inc = idx + 1'b1;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        par_nxt   = par_bit;
        tx_nxt    = tx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                // A cke in the accept cycle is deliberately not acted on; SYNC waits for the next one.
                if (valid && ready) begin
                    shreg_nxt = data;
                    par_nxt   = (PARITY == 1) ? ~^data : ^data;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (cke) begin
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (cke) begin
                    tx_nxt    = shreg[0];
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (cke) begin
                    if (idx < LAST_IDX) begin
                        tx_nxt  = shreg[idx_inc];
                        idx_nxt = idx_inc;
                    end else if (PARITY != 0) begin
                        tx_nxt    = par_bit;
                        state_nxt = PAR;
                    end else begin
                        tx_nxt    = 1'b1;
                        cnt_nxt   = 1'b0;
                        state_nxt = STOP;
                    end
                end
            end
            PAR: begin
                if (cke) begin
                    tx_nxt    = 1'b1;
                    cnt_nxt   = 1'b0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cke) begin
                    if (STOP_BITS == 2 && !cnt) begin
                        cnt_nxt = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ready/busy are registered copies of the next state, so they flip together with done.
    assign ready_nxt = (state_nxt == IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            cnt     <= 1'b0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            par_bit <= par_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
            busy    <= !ready_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven side by side and checked each cycle against a frame-queue model.
module tb_uart_tx;

    localparam int NI = 4;

    logic       clk  = 1'b0;
    logic       rst_ = 1'b0;
    logic       cke  = 1'b0;
    logic [7:0] dat [NI];
    logic       vld [NI];
    logic       rdy [NI];
    logic       txo [NI];
    logic       bsy [NI];
    logic       dn  [NI];

    int total = 0;
    int bad   = 0;
    int ckp   = 4;
    int ckcnt = 0;
    bit ck_rand = 1'b0;

    // model state
    logic m_tx [NI];
    logic m_rdy [NI];
    logic m_bsy [NI];
    logic m_dn [NI];
    bit   m_act [NI];
    bit   fb [NI][16];
    int   flen [NI];
    int   fpos [NI];
    int   ncke [NI];
    bit   acc [NI];
    bit   smp [NI];
    bit   pdn;
    bit   rec [NI][32];
    int   nrec [NI];

    int kf;
    int dcount;
    bit ok;
    bit pdone;

    function automatic int nb(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int np(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int ns(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    uart_tx u0 (.clk(clk), .rst_(rst_), .cke(cke), .data(dat[0]), .valid(vld[0]),
                .ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx #(.PARITY(2)) u1 (.clk(clk), .rst_(rst_), .cke(cke), .data(dat[1]), .valid(vld[1]),
                .ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx #(.PARITY(1)) u2 (.clk(clk), .rst_(rst_), .cke(cke), .data(dat[2]), .valid(vld[2]),
                .ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));
    uart_tx #(.DATA_BITS(5), .STOP_BITS(2)) u3 (.clk(clk), .rst_(rst_), .cke(cke), .data(dat[3][4:0]),
                .valid(vld[3]), .ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .done(dn[3]));

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ckcnt++;
        if (ckcnt >= ckp) begin
            cke   = 1'b1;
            ckcnt = 0;
            if (ck_rand) ckp = $urandom_range(1, 5);
        end else begin
            cke = 1'b0;
        end
    end

    task automatic chk(input string nm, input int i, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%b want=%b t=%0t", nm, i, got, want, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int i, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d t=%0t", nm, i, got, want, $time);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s got=expired want=event t=%0t", nm, $time);
    endtask

    // Frame = start, data LSB first, parity chosen to make the one-count odd/even, stop ones.
    task automatic build(input int i, input logic [7:0] w);
        int n;
        int ones;
        n = 0;
        ones = 0;
        fb[i][n] = 1'b0;
        n++;
        for (int b = 0; b < nb(i); b++) begin
            fb[i][n] = w[b];
            n++;
            ones += int'(w[b]);
        end
        if (np(i) == 1) begin
            fb[i][n] = (ones % 2 == 0);
            n++;
        end else if (np(i) == 2) begin
            fb[i][n] = (ones % 2 == 1);
            n++;
        end
        for (int s = 0; s < ns(i); s++) begin
            fb[i][n] = 1'b1;
            n++;
        end
        flen[i] = n;
        fpos[i] = 0;
    endtask

    task automatic mreset();
        for (int i = 0; i < NI; i++) begin
            m_tx[i] = 1'b1; m_rdy[i] = 1'b1; m_bsy[i] = 1'b0; m_dn[i] = 1'b0;
            m_act[i] = 1'b0; acc[i] = 1'b0; smp[i] = 1'b0; fpos[i] = 0; flen[i] = 0;
        end
    endtask

    // Each cke while a frame is pending puts the next queued bit on the line; one more ends it.
    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_);
            if (!rst_) begin
                mreset();
            end else begin
                for (int i = 0; i < NI; i++) begin
                    pdn = m_dn[i];
                    m_dn[i] = 1'b0;
                    acc[i] = 1'b0;
                    smp[i] = 1'b0;
                    if (m_act[i]) begin
                        if (cke) begin
                            ncke[i]++;
                            if (fpos[i] < flen[i]) begin
                                m_tx[i] = fb[i][fpos[i]];
                                fpos[i]++;
                                smp[i] = 1'b1;
                            end else begin
                                m_act[i] = 1'b0; m_rdy[i] = 1'b1; m_bsy[i] = 1'b0; m_dn[i] = 1'b1;
                            end
                        end
                    end else if (vld[i]) begin
                        build(i, dat[i]);
                        m_act[i] = 1'b1; m_rdy[i] = 1'b0; m_bsy[i] = 1'b1;
                        acc[i] = 1'b1; ncke[i] = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("tx", i, txo[i], m_tx[i]);
            chk("ready", i, rdy[i], m_rdy[i]);
            chk("busy", i, bsy[i], m_bsy[i]);
            chk("done", i, dn[i], m_dn[i]);
            if (smp[i] && nrec[i] < 32) begin
                rec[i][nrec[i]] = txo[i];
                nrec[i]++;
            end
        end
    end

    task automatic send(input int i, input logic [7:0] w);
        bit got;
        got = 1'b0;
        @(negedge clk);
        vld[i] = 1'b1;
        dat[i] = w;
        nrec[i] = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc[i]) begin
                got = 1'b1;
                break;
            end
        end
        vld[i] = 1'b0;
        dat[i] = 8'($urandom);
        if (!got) tmo("accept");
    endtask

    task automatic wait_done(input int i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (dn[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo("done");
    endtask

    // lit holds the expected line bits, first bit in the most significant used position.
    task automatic chk_frame(input string nm, input int i, input logic [31:0] lit, input int len, input int kck);
        chk_int({nm, "_len"}, i, nrec[i], len);
        for (int k = 0; k < len && k < nrec[i]; k++)
            chk({nm, "_bit"}, k, rec[i][k], lit[len-1-k]);
        chk_int({nm, "_cke"}, i, ncke[i], kck);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
            nrec[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_tx", i, txo[i], 1'b1);
            chk("rst_ready", i, rdy[i], 1'b1);
            chk("rst_busy", i, bsy[i], 1'b0);
            chk("rst_done", i, dn[i], 1'b0);
        end
        rst_ = 1'b1;

        send(0, 8'hA5); wait_done(0); chk_frame("a5", 0, 32'b0101001011, 10, 11);
        send(1, 8'hA5); wait_done(1); chk_frame("a5_even", 1, 32'b01010010101, 11, 12);
        send(2, 8'hA5); wait_done(2); chk_frame("a5_odd", 2, 32'b01010010111, 11, 12);
        send(3, 8'h1F); wait_done(3); chk_frame("1f_d5s2", 3, 32'b01111111, 8, 9);

        // valid raised in the same cycle as a cke
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (cke) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo("cke_align");
        vld[0] = 1'b1;
        dat[0] = 8'hC3;
        nrec[0] = 0;
        @(negedge clk);
        chk("acc_with_cke", 0, acc[0], 1'b1);
        vld[0] = 1'b0;
        dat[0] = 8'h00;
        kf = -1;
        for (int k = 1; k < 40; k++) begin
            if (txo[0] === 1'b0) begin
                kf = k;
                break;
            end
            @(negedge clk);
        end
        chk_int("fall_after_cke", 0, kf, 5);
        wait_done(0); chk_frame("c3", 0, 32'b0110000111, 10, 11);

        // valid held across two words
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 8'h55;
        nrec[0] = 0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo("b2b_first");
        dat[0] = 8'h33;
        ok = 1'b0;
        pdone = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (acc[0]) begin
                ok = 1'b1;
                break;
            end
            pdone = dn[0];
        end
        if (!ok) tmo("b2b_second");
        chk("accept_when_ready_returns", 0, pdone, 1'b1);
        vld[0] = 1'b0;
        dat[0] = 8'hFF;
        kf = -1;
        for (int k = 0; k < 40; k++) begin
            if (txo[0] === 1'b0) begin
                kf = k;
                break;
            end
            @(negedge clk);
        end
        chk_int("sync_gap", 0, kf, 3);
        wait_done(0); chk_frame("b2b", 0, 32'b01010101010110011001, 20, 11);

        // reset while data bit 3 (a zero) is on the line
        send(0, 8'h96);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (nrec[0] >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo("reach_bit3");
        chk("bit3_low", 0, txo[0], 1'b0);
        #2;
        rst_ = 1'b0;
        #1;
        chk("abort_tx", 0, txo[0], 1'b1);
        chk("abort_ready", 0, rdy[0], 1'b1);
        chk("abort_busy", 0, bsy[0], 1'b0);
        chk("abort_done", 0, dn[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn[0] === 1'b1) dcount++;
        end
        chk_int("no_done_after_abort", 0, dcount, 0);
        send(0, 8'h3C); wait_done(0); chk_frame("after_rst", 0, 32'b0001111001, 10, 11);

        // random traffic, random bit periods
        ck_rand = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 1) == 1) vld[i] = 1'b0;
                    else dat[i] = 8'($urandom);
                end else if (!vld[i]) begin
                    dat[i] = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) vld[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NI; i++) vld[i] = 1'b0;
        repeat (200) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
